// File: rtl/io_port_responder_if.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module      : io_port_responder_if
// Description : CPU-side port selects and IN/OUT strobes seen by a responder.
// Revision    : 1.0 - initial release
//////////////////////////////////////////////////////////////////////////////
interface io_port_responder_if;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic       outn;
    logic       inn;

    modport master (output sel_x, sel_y, outn, inn);
    modport slave  (input  sel_x, sel_y, outn, inn);
endinterface
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module      : io_port_responder
// Description : I/O-port responder with data/status ports and TX/RX FIFOs.
// Revision    : 1.0 - initial release
//////////////////////////////////////////////////////////////////////////////
module io_port_responder #(
    parameter int DATA_X     = 1,
    parameter int DATA_Y     = 0,
    parameter int STAT_X     = 2,
    parameter int STAT_Y     = 0,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    io_port_responder_if.slave cpu,
    inout  wire  [7:0]         bus,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               irq
);

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam int                c_CW    = DEPTH_LOG2 + 1;
    localparam logic [c_CW-1:0]   c_FULL  = c_CW'(c_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            r_tx_mem [c_DEPTH];
    logic [7:0]            r_rx_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [c_CW-1:0]       r_tx_cnt, r_rx_cnt;
    logic                  r_tx_ovf, r_rx_ovf;

    logic w_dsel, w_ssel, w_wr, w_rd;
    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_flush, w_clr;
    logic w_tx_push, w_tx_drop, w_tx_pop;
    logic w_rx_push, w_rx_drop, w_rx_pop;
    logic [2:0] w_rx_cnt_sat;
    logic [7:0] w_status, w_bus_out;
    logic       w_bus_oe;
    logic       w_unused;

    // Data port takes priority if both decodes hit the same select pair.
    assign w_dsel = ~cpu.sel_x[DATA_X] & ~cpu.sel_y[DATA_Y];
    assign w_ssel = ~cpu.sel_x[STAT_X] & ~cpu.sel_y[STAT_Y] & ~w_dsel;
    assign w_wr   = ~cpu.outn &  cpu.inn;
    assign w_rd   =  cpu.outn & ~cpu.inn;
    assign w_unused = &{1'b0, cpu.sel_x, cpu.sel_y};

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_FULL);

    assign w_flush = w_wr & w_ssel & bus[7];
    assign w_clr   = w_ssel & (w_rd | (w_wr & bus[6]));

    assign w_tx_push = w_wr & w_dsel & ~w_tx_full;
    assign w_tx_drop = w_wr & w_dsel &  w_tx_full;
    assign w_tx_pop  = ~w_tx_empty & tx_ready;
    assign w_rx_push = rx_valid & ~w_rx_full;
    assign w_rx_drop = rx_valid &  w_rx_full;
    assign w_rx_pop  = w_rd & w_dsel & ~w_rx_empty;

    generate
        if (c_CW <= 3) begin : g_cnt_narrow
            assign w_rx_cnt_sat = 3'(r_rx_cnt);
        end else begin : g_cnt_wide
            assign w_rx_cnt_sat = (|r_rx_cnt[c_CW-1:3]) ? 3'd7 : r_rx_cnt[2:0];
        end
    endgenerate

    assign w_status = {w_rx_cnt_sat, r_rx_ovf, r_tx_ovf, w_tx_empty, ~w_tx_full, ~w_rx_empty};
    assign w_bus_out = w_dsel ? (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]) : w_status;
    assign w_bus_oe  = w_rd & (w_dsel | w_ssel);
    assign bus       = w_bus_oe ? w_bus_out : 8'hzz;

    assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];
    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;
    assign irq      = ~w_rx_empty | r_tx_ovf | r_rx_ovf;

    // A flush discards every same-edge push and pop; overflow flags still record drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_flush) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_rx_wp  <= '0;
                r_rx_rp  <= '0;
                r_tx_cnt <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + c_PTR_ONE;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PTR_ONE;
                if (w_rx_push) r_rx_wp <= r_rx_wp + c_PTR_ONE;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PTR_ONE;
                r_tx_cnt <= r_tx_cnt + c_CW'(w_tx_push) - c_CW'(w_tx_pop);
                r_rx_cnt <= r_rx_cnt + c_CW'(w_rx_push) - c_CW'(w_rx_pop);
            end
            if (w_tx_drop)  r_tx_ovf <= 1'b1;
            else if (w_clr) r_tx_ovf <= 1'b0;
            if (w_rx_drop)  r_rx_ovf <= 1'b1;
            else if (w_clr) r_rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push && !w_flush) r_tx_mem[r_tx_wp] <= bus;
        if (w_rx_push && !w_flush) r_rx_mem[r_rx_wp] <= rx_data;
    end

endmodule
`default_nettype wire
